spi_sclk_gen: RTL and testbench

- Programmable SPI serial-clock generator; successor to the fixed divide-by-N clock divider.
- Runtime half-period divisor, selectable idle polarity (CPOL), burst mode producing an exact number of SCLK cycles, and single-cycle edge strobes for the shift logic.
- Sits between the SPI master control FSM and the shift register; all outputs are registered in the clk domain, and SCLK is never used as a clock internally.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_sclk_gen.sv | 127 ++++++++++++
 tb/tb_spi_sclk_gen.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI serial-clock generator
package spi_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } spi_state_t;

   localparam int DIV_W_DEF   = 8;
   localparam int BURST_W_DEF = 6;

   // Smallest usable half-period; a programmed divisor of 0 is promoted to this.
   localparam int MIN_HALF    = 1;

endpackage

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - programmable SPI SCLK generator with burst count and edge strobes
module spi_sclk_gen
   import spi_pkg::*;
#(
   parameter int DIV_W   = DIV_W_DEF,
   parameter int BURST_W = BURST_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic               cpol,
   input  logic [DIV_W-1:0]   half_div,
   input  logic [BURST_W-1:0] n_cycles,
   output logic               sclk,
   output logic               lead_stb,
   output logic               trail_stb,
   output logic               busy,
   output logic               done
);

   spi_state_t         state_q, state_d;
   logic [DIV_W-1:0]   div_cnt, div_cnt_d;
   logic [BURST_W:0]   edge_cnt, edge_cnt_d;
   logic [BURST_W:0]   edge_nxt;
   logic [DIV_W-1:0]   h_q, h_d;
   logic [BURST_W-1:0] c_q, c_d;
   logic               cpol_q, cpol_d;
   logic               sclk_d, lead_d, trail_d, busy_d, done_d;

   // Register the FSM state, counters, latched burst settings and all outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         div_cnt   <= '0;
         edge_cnt  <= '0;
         h_q       <= '0;
         c_q       <= '0;
         cpol_q    <= 1'b0;
         sclk      <= 1'b0;
         lead_stb  <= 1'b0;
         trail_stb <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_cnt   <= div_cnt_d;
         edge_cnt  <= edge_cnt_d;
         h_q       <= h_d;
         c_q       <= c_d;
         cpol_q    <= cpol_d;
         sclk      <= sclk_d;
         lead_stb  <= lead_d;
         trail_stb <= trail_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

   // Edge number of the toggle that would happen this cycle; odd is leading, even trailing.
   assign edge_nxt = edge_cnt + (BURST_W+1)'(1);

   // Next-state and output decode: idle tracking, burst launch, half-period count, abort.
   always_comb begin
      state_d    = state_q;
      div_cnt_d  = div_cnt;
      edge_cnt_d = edge_cnt;
      h_d        = h_q;
      c_d        = c_q;
      cpol_d     = cpol_q;
      sclk_d     = sclk;
      lead_d     = 1'b0;
      trail_d    = 1'b0;
      busy_d     = busy;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            sclk_d = cpol;
            busy_d = 1'b0;
            if (start) begin
               if (n_cycles != '0) begin
                  h_d        = (half_div == '0) ? DIV_W'(MIN_HALF) : half_div;
                  c_d        = n_cycles;
                  cpol_d     = cpol;
                  div_cnt_d  = '0;
                  edge_cnt_d = '0;
                  busy_d     = 1'b1;
                  state_d    = RUN;
               end else begin
                  // Empty burst completes immediately without any SCLK activity.
                  done_d = 1'b1;
               end
            end
         end

         RUN: begin
            if (abort) begin
               // Abort beats a coincident toggle and suppresses done.
               sclk_d     = cpol_q;
               busy_d     = 1'b0;
               div_cnt_d  = '0;
               edge_cnt_d = '0;
               state_d    = IDLE;
            end else if (div_cnt == h_q - DIV_W'(1)) begin
               div_cnt_d  = '0;
               sclk_d     = ~sclk;
               edge_cnt_d = edge_nxt;
               lead_d     = edge_nxt[0];
               trail_d    = ~edge_nxt[0];
               if (edge_nxt == {c_q, 1'b0}) begin
                  sclk_d     = cpol_q;
                  busy_d     = 1'b0;
                  done_d     = 1'b1;
                  edge_cnt_d = '0;
                  state_d    = IDLE;
               end
            end else begin
               div_cnt_d = div_cnt + DIV_W'(1);
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb/tb_spi_sclk_gen.sv - self-checking bench for spi_sclk_gen against a cycle-arithmetic model
module tb_spi_sclk_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic       cpol;
   logic [7:0] half_div;
   logic [5:0] n_cycles;
   logic       sclk;
   logic       lead_stb;
   logic       trail_stb;
   logic       busy;
   logic       done;

   int n_vec  = 0;
   int n_fail = 0;

   spi_sclk_gen #(.DIV_W(8), .BURST_W(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .cpol      (cpol),
      .half_div  (half_div),
      .n_cycles  (n_cycles),
      .sclk      (sclk),
      .lead_stb  (lead_stb),
      .trail_stb (trail_stb),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic e_sclk, input logic e_lead,
                          input logic e_trail, input logic e_busy, input logic e_done);
      chk({tag, ".sclk"},      sclk,      e_sclk);
      chk({tag, ".lead_stb"},  lead_stb,  e_lead);
      chk({tag, ".trail_stb"}, trail_stb, e_trail);
      chk({tag, ".busy"},      busy,      e_busy);
      chk({tag, ".done"},      done,      e_done);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One burst launched at edge t. After edge t+j the model says: m = j/H toggles
   // have happened, so sclk = cpol ^ (m odd); a toggle lands exactly when H divides j,
   // and it is a leading edge for odd m, trailing for even m; busy lasts 2*C*H cycles.
   // ab_at / st_at: edge index (relative to t) where abort / a stray start is sampled, 0 = none.
   task automatic run_burst(input logic cp, input int hd, input int nc,
                            input int ab_at, input int st_at, input bit b2b);
      int   h;
      int   total;
      int   m;
      logic tog;
      logic cpl;
      h     = (hd == 0) ? 1 : hd;
      total = 2 * nc * h;
      cpl   = cp;
      start    = 1'b1;
      cpol     = cp;
      half_div = hd[7:0];
      n_cycles = nc[5:0];
      abort    = 1'($urandom_range(0, 1));
      tick();
      start = 1'b0;
      abort = 1'b0;
      if (nc == 0) begin
         chk_out("zero_burst", cpl, 1'b0, 1'b0, 1'b0, 1'b1);
      end else begin
         chk_out("launch", cpl, 1'b0, 1'b0, 1'b1, 1'b0);
         cpol     = 1'($urandom);
         half_div = 8'($urandom);
         n_cycles = 6'($urandom);
         start    = (st_at == 1);
         abort    = (ab_at == 1);
         for (int j = 1; j <= total; j++) begin
            tick();
            if (ab_at == j) begin
               chk_out("abort", cpl, 1'b0, 1'b0, 1'b0, 1'b0);
               break;
            end
            m   = j / h;
            tog = ((j % h) == 0);
            chk_out("run", cpl ^ m[0], tog && m[0], tog && !m[0], j < total, j == total);
            start = (j + 1 == st_at);
            abort = (j + 1 == ab_at);
         end
         start = 1'b0;
         abort = 1'b0;
      end
      if (!b2b) begin
         abort = 1'($urandom);
         tick();
         chk_out("idle_after", cpol, 1'b0, 1'b0, 1'b0, 1'b0);
         abort = 1'b0;
      end
   endtask

   initial begin
      int hd;
      int nc;
      int total;
      int ab;
      int st;

      rst_n    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      cpol     = 1'b1;
      half_div = 8'd0;
      n_cycles = 6'd0;
      repeat (2) tick();
      chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      rst_n = 1'b1;
      tick();
      chk_out("idle_cpol1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      abort = 1'b1;
      cpol  = 1'b0;
      tick();
      chk_out("idle_abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      abort = 1'b0;

      run_burst(1'b0, 2, 2, 0, 0, 1'b0);
      run_burst(1'b1, 0, 3, 0, 0, 1'b0);
      run_burst(1'b1, 5, 0, 0, 0, 1'b0);
      run_burst(1'b0, 3, 4, 8, 4, 1'b0);
      run_burst(1'b1, 2, 2, 8, 0, 1'b0);
      run_burst(1'b0, 2, 3, 0, 12, 1'b1);
      run_burst(1'b0, 5, 2, 0, 0, 1'b0);
      run_burst(1'b1, 1, 2, 0, 0, 1'b1);
      run_burst(1'b0, 1, 1, 0, 0, 1'b1);
      run_burst(1'b0, 0, 0, 0, 0, 1'b1);
      run_burst(1'b1, 255, 1, 0, 0, 1'b0);

      // Asynchronous reset three edges into an H=2 burst, while sclk is high.
      start    = 1'b1;
      cpol     = 1'b0;
      half_div = 8'd2;
      n_cycles = 6'd4;
      tick();
      start = 1'b0;
      chk_out("rst_launch", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk_out("rst_j1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk_out("rst_j2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk_out("rst_j3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_out("rst_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      run_burst(1'b1, 2, 2, 0, 0, 1'b0);

      for (int i = 0; i < 30; i++) begin
         hd    = $urandom_range(0, 9);
         nc    = $urandom_range(0, 7);
         total = 2 * nc * ((hd == 0) ? 1 : hd);
         ab    = 0;
         st    = 0;
         if (total > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, total);
         if (total > 0 && ab != 1 && $urandom_range(0, 1) == 1)
            st = $urandom_range(1, (ab != 0) ? ab - 1 : total);
         run_burst(1'($urandom), hd, nc, ab, st, 1'($urandom_range(0, 1)));
      end

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
